// File: rtl/hamming_secded_codec.sv
// Extended-Hamming SECDED encoder/decoder pair with valid/ready handshakes.
// Latency: encoder 1 cycle, decoder 2 cycles; both sustain one word per cycle.
// Backpressure: each channel stalls in place when its output is valid and not taken.
// Optional HAMMING_ERR_INJECT_EN: adds inj_mask, XORed into each encoded word.
module hamming_secded_codec #(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // encoder
    input  logic                    enc_in_valid,
    output logic                    enc_in_ready,
    input  logic [DATA_W-1:0]       enc_data_in,
    output logic                    enc_out_valid,
    input  logic                    enc_out_ready,
    output logic [DATA_W+PAR_W:0]   enc_code_out,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [DATA_W+PAR_W:0]   inj_mask,
`endif
    // decoder
    input  logic                    dec_in_valid,
    output logic                    dec_in_ready,
    input  logic [DATA_W+PAR_W:0]   dec_code_in,
    output logic                    dec_out_valid,
    input  logic                    dec_out_ready,
    output logic [DATA_W-1:0]       dec_data_out,
    output logic [1:0]              dec_status,
    output logic [PAR_W-1:0]        dec_err_pos,
    // statistics
    input  logic                    clr_cnt,
    output logic [CNT_W-1:0]        corr_cnt,
    output logic [CNT_W-1:0]        uncorr_cnt
);

    localparam int CODE_W = DATA_W + PAR_W + 1;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_CORR  = 2'b01;
    localparam logic [1:0] ST_DBL   = 2'b10;
    localparam logic [1:0] ST_RANGE = 2'b11;

    // Data bits go to non-power-of-two positions, LSB first; then Hamming
    // parity at powers of two; then bit 0 makes the whole word even parity.
    function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic              b;
        int                j;
        c = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (j < DATA_W) c[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < PAR_W; k++) begin
            if ((1 << k) < CODE_W) begin
                b = 1'b0;
                for (int i = 1; i < CODE_W; i++) begin
                    if (((i >> k) & 1) == 1) b = b ^ c[i];
                end
                c[1 << k] = b;
            end
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    // Inverse of the data placement used by f_encode.
    function automatic logic [DATA_W-1:0] f_extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (j < DATA_W) d[j] = c[i];
                j++;
            end
        end
        return d;
    endfunction

    // XOR of the indices of all set bits above the overall-parity bit.
    function automatic logic [PAR_W-1:0] f_syndrome(input logic [CODE_W-1:0] c);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (c[i]) s = s ^ PAR_W'(i);
        end
        return s;
    endfunction

    // ---------------- encoder ----------------
    logic              r_enc_vld;
    logic [CODE_W-1:0] r_enc_code;
    logic              w_enc_adv;
    logic [CODE_W-1:0] w_enc_word;

    assign w_enc_adv = !r_enc_vld || enc_out_ready;

`ifdef HAMMING_ERR_INJECT_EN
    assign w_enc_word = f_encode(enc_data_in) ^ inj_mask;
`else
    assign w_enc_word = f_encode(enc_data_in);
`endif

    // Single output register; holds the word while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_vld  <= 1'b0;
            r_enc_code <= '0;
        end else if (w_enc_adv) begin
            r_enc_vld <= enc_in_valid;
            if (enc_in_valid) r_enc_code <= w_enc_word;
        end
    end

    assign enc_in_ready  = w_enc_adv;
    assign enc_out_valid = r_enc_vld;
    assign enc_code_out  = r_enc_code;

    // ---------------- decoder ----------------
    logic              r_s1_vld;
    logic [CODE_W-1:0] r_s1_code;
    logic [PAR_W-1:0]  r_s1_syn;
    logic              r_s1_par;
    logic              r_dec_vld;
    logic [DATA_W-1:0] r_dec_data;
    logic [1:0]        r_dec_status;
    logic [PAR_W-1:0]  r_dec_pos;
    logic              w_dec_adv;
    logic              w_out_xfer;
    logic [CODE_W-1:0] w_fix_code;
    logic [1:0]        w_status;
    logic [PAR_W-1:0]  w_pos;

    // Whole pipeline moves together; an empty output stage always advances,
    // so bubbles never block a word waiting in S1.
    assign w_dec_adv  = !r_dec_vld || dec_out_ready;
    assign w_out_xfer = r_dec_vld && dec_out_ready;

    // S1: capture word with its syndrome and overall parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_code <= '0;
            r_s1_syn  <= '0;
            r_s1_par  <= 1'b0;
        end else if (w_dec_adv) begin
            r_s1_vld <= dec_in_valid;
            if (dec_in_valid) begin
                r_s1_code <= dec_code_in;
                r_s1_syn  <= f_syndrome(dec_code_in);
                r_s1_par  <= ^dec_code_in;
            end
        end
    end

    // Classify the S1 word and flip the single failing bit when correctable.
    always_comb begin
        w_fix_code = r_s1_code;
        w_status   = ST_CLEAN;
        w_pos      = '0;
        if (r_s1_par) begin
            if (r_s1_syn == '0) begin
                w_status = ST_CORR;
            end else if (int'(r_s1_syn) <= CODE_W - 1) begin
                w_status = ST_CORR;
                w_pos    = r_s1_syn;
                for (int i = 1; i < CODE_W; i++) begin
                    if (int'(r_s1_syn) == i) w_fix_code[i] = ~r_s1_code[i];
                end
            end else begin
                w_status = ST_RANGE;
            end
        end else if (r_s1_syn != '0) begin
            w_status = ST_DBL;
        end
    end

    // S2: registered corrected data and status; held stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_vld    <= 1'b0;
            r_dec_data   <= '0;
            r_dec_status <= ST_CLEAN;
            r_dec_pos    <= '0;
        end else if (w_dec_adv) begin
            r_dec_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_dec_data   <= f_extract(w_fix_code);
                r_dec_status <= w_status;
                r_dec_pos    <= w_pos;
            end
        end
    end

    assign dec_in_ready  = w_dec_adv;
    assign dec_out_valid = r_dec_vld;
    assign dec_data_out  = r_dec_data;
    assign dec_status    = r_dec_status;
    assign dec_err_pos   = r_dec_pos;

    // ---------------- counters ----------------
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    // Saturating counts, bumped only when a decoded word is actually taken;
    // a clear beats a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_dec_status == ST_CORR && r_corr_cnt != '1)
                r_corr_cnt <= r_corr_cnt + 1'b1;
            if (r_dec_status[1] && r_uncorr_cnt != '1)
                r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for hamming_secded_codec (11/4 code, 2-bit counters).
// Inputs driven 1 ns after the rising edge, outputs sampled away from it.
// Expected values are hand-computed constants and a small counter model.
module tb_hamming_secded_codec;

    localparam int DATA_W = 11;
    localparam int PAR_W  = 4;
    localparam int CNT_W  = 2;
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              enc_in_valid;
    logic              enc_in_ready;
    logic [DATA_W-1:0] enc_data_in;
    logic              enc_out_valid;
    logic              enc_out_ready;
    logic [CODE_W-1:0] enc_code_out;
`ifdef HAMMING_ERR_INJECT_EN
    logic [CODE_W-1:0] inj_mask;
`endif
    logic              dec_in_valid;
    logic              dec_in_ready;
    logic [CODE_W-1:0] dec_code_in;
    logic              dec_out_valid;
    logic              dec_out_ready;
    logic [DATA_W-1:0] dec_data_out;
    logic [1:0]        dec_status;
    logic [PAR_W-1:0]  dec_err_pos;
    logic              clr_cnt;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hamming_secded_codec #(
        .DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_in_valid (enc_in_valid),
        .enc_in_ready (enc_in_ready),
        .enc_data_in  (enc_data_in),
        .enc_out_valid(enc_out_valid),
        .enc_out_ready(enc_out_ready),
        .enc_code_out (enc_code_out),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_mask     (inj_mask),
`endif
        .dec_in_valid (dec_in_valid),
        .dec_in_ready (dec_in_ready),
        .dec_code_in  (dec_code_in),
        .dec_out_valid(dec_out_valid),
        .dec_out_ready(dec_out_ready),
        .dec_data_out (dec_data_out),
        .dec_status   (dec_status),
        .dec_err_pos  (dec_err_pos),
        .clr_cnt      (clr_cnt),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one word through an otherwise empty decoder with the output ready.
    task automatic dec_one(input logic [CODE_W-1:0] code, input logic [DATA_W-1:0] ed,
                           input logic [1:0] es, input logic [PAR_W-1:0] ep);
        dec_code_in  = code;
        dec_in_valid = 1'b1;
        tick();
        dec_in_valid = 1'b0;
        chk("dec_lat1_vld", dec_out_valid, 0);
        tick();
        chk("dec_vld",    dec_out_valid, 1);
        chk("dec_data",   dec_data_out, ed);
        chk("dec_status", dec_status, es);
        chk("dec_pos",    dec_err_pos, ep);
        tick();
    endtask

    // Stream contents for the backpressure run.
    logic [CODE_W-1:0] bp_code [0:4] = '{16'hFFFF, 16'hFFFB, 16'h000F, 16'hFFF3, 16'h000E};
    logic [DATA_W-1:0] bp_data [0:4] = '{11'h7FF, 11'h7FF, 11'h001, 11'h7FE, 11'h001};
    logic [1:0]        bp_st   [0:4] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [PAR_W-1:0]  bp_pos  [0:4] = '{4'd0, 4'd2, 4'd0, 4'd0, 4'd0};

    initial begin
        int               sent;
        int               rcvd;
        logic [CNT_W-1:0] exp_corr;
        logic [CNT_W-1:0] exp_unc;
        logic             stalled_prev;
        logic [DATA_W-1:0] held_data;
        logic [1:0]        held_st;

        // ---- reset with both input valids asserted ----
        rst           = 1'b1;
        enc_in_valid  = 1'b1;
        enc_data_in   = 11'h7FF;
        enc_out_ready = 1'b1;
        dec_in_valid  = 1'b1;
        dec_code_in   = 16'hFFFF;
        dec_out_ready = 1'b1;
        clr_cnt       = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        inj_mask      = '0;
`endif
        tick();
        tick();
        chk("rst_enc_vld",  enc_out_valid, 0);
        chk("rst_enc_code", enc_code_out, 0);
        chk("rst_dec_vld",  dec_out_valid, 0);
        chk("rst_dec_data", dec_data_out, 0);
        chk("rst_dec_st",   dec_status, 0);
        chk("rst_dec_pos",  dec_err_pos, 0);
        chk("rst_corr",     corr_cnt, 0);
        chk("rst_uncorr",   uncorr_cnt, 0);
        rst          = 1'b0;
        enc_in_valid = 1'b0;
        dec_in_valid = 1'b0;
        @(negedge clk);
        chk("rdy_enc", enc_in_ready, 1);
        chk("rdy_dec", dec_in_ready, 1);
        tick();

        // ---- encoder, back-to-back ----
        enc_in_valid = 1'b1;
        enc_data_in  = 11'h7FF;
        tick();
        chk("enc_vld0", enc_out_valid, 1);
        chk("enc_7ff",  enc_code_out, 16'hFFFF);
        enc_data_in = 11'h001;
        tick();
        chk("enc_001", enc_code_out, 16'h000F);
        enc_in_valid = 1'b0;
        tick();
        chk("enc_idle", enc_out_valid, 0);

        // ---- encoder stall ----
        enc_out_ready = 1'b0;
        enc_in_valid  = 1'b1;
        enc_data_in   = 11'h001;
        tick();
        enc_data_in = 11'h7FF;
        chk("enc_stall_rdy", enc_in_ready, 0);
        tick();
        chk("enc_stall_hold", enc_code_out, 16'h000F);
        enc_out_ready = 1'b1;
        tick();
        chk("enc_resume", enc_code_out, 16'hFFFF);
        enc_in_valid = 1'b0;
        tick();

        // ---- decoder: single errors, double error, clean ----
        dec_one(16'hFFFB, 11'h7FF, 2'b01, 4'd2);
        chk("corr_after_1", corr_cnt, 1);
        dec_one(16'hFFFE, 11'h7FF, 2'b01, 4'd0);
        chk("corr_after_2", corr_cnt, 2);
        dec_one(16'hFFF3, 11'h7FE, 2'b10, 4'd0);
        chk("unc_after_dbl",  uncorr_cnt, 1);
        chk("corr_after_dbl", corr_cnt, 2);
        dec_one(16'hFFFF, 11'h7FF, 2'b00, 4'd0);
        chk("corr_after_clean", corr_cnt, 2);

        // ---- backpressure stream ----
        clr_cnt = 1'b1;
        tick();
        clr_cnt      = 1'b0;
        exp_corr     = '0;
        exp_unc      = '0;
        sent         = 0;
        rcvd         = 0;
        stalled_prev = 1'b0;
        held_data    = '0;
        held_st      = '0;
        for (int cyc = 0; cyc < 30 && rcvd < 5; cyc++) begin
            dec_out_ready = !(cyc >= 4 && cyc < 7);
            dec_in_valid  = (sent < 5);
            dec_code_in   = (sent < 5) ? bp_code[sent] : '0;
            @(negedge clk);
            chk("bp_corr", corr_cnt, exp_corr);
            chk("bp_unc",  uncorr_cnt, exp_unc);
            if (dec_out_valid && !dec_out_ready)
                chk("bp_in_rdy_low", dec_in_ready, 0);
            if (stalled_prev) begin
                chk("bp_hold_vld",  dec_out_valid, 1);
                chk("bp_hold_data", dec_data_out, held_data);
                chk("bp_hold_st",   dec_status, held_st);
            end
            if (dec_out_valid && dec_out_ready) begin
                chk("bp_data", dec_data_out, bp_data[rcvd]);
                chk("bp_st",   dec_status, bp_st[rcvd]);
                chk("bp_pos",  dec_err_pos, bp_pos[rcvd]);
                if (bp_st[rcvd] == 2'b01 && exp_corr != '1) exp_corr = exp_corr + 1'b1;
                if (bp_st[rcvd][1] && exp_unc != '1) exp_unc = exp_unc + 1'b1;
                rcvd++;
            end
            stalled_prev = dec_out_valid && !dec_out_ready;
            held_data    = dec_data_out;
            held_st      = dec_status;
            if (dec_in_valid && dec_in_ready) sent++;
            tick();
        end
        dec_in_valid  = 1'b0;
        dec_out_ready = 1'b1;
        chk("bp_count", rcvd, 5);
        tick();
        tick();
        chk("bp_no_dup", dec_out_valid, 0);
        chk("bp_corr_final", corr_cnt, 2);
        chk("bp_unc_final",  uncorr_cnt, 1);

        // ---- counter saturation and clear-wins ----
        clr_cnt = 1'b1;
        tick();
        clr_cnt      = 1'b0;
        dec_code_in  = 16'hFFFB;
        dec_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        dec_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("sat_corr",  corr_cnt, 3);
        chk("sat_drain", dec_out_valid, 0);
        dec_in_valid = 1'b1;
        tick();
        dec_in_valid = 1'b0;
        tick();
        chk("clr_xfer_vld", dec_out_valid, 1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_wins", corr_cnt, 0);

        // ---- reset mid-flight drops the word ----
        dec_code_in  = 16'hFFFB;
        dec_in_valid = 1'b1;
        tick();
        dec_in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_vld", dec_out_valid, 0);
        tick();
        chk("rst_mid_corr", corr_cnt, 0);

`ifdef HAMMING_ERR_INJECT_EN
        // ---- error injection on the encoder path ----
        inj_mask     = 16'h0004;
        enc_data_in  = 11'h7FF;
        enc_in_valid = 1'b1;
        tick();
        enc_in_valid = 1'b0;
        inj_mask     = '0;
        chk("inj_code", enc_code_out, 16'hFFFB);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
